// File: rtl/fcmp_unit.sv
// fcmp_unit: 2-stage valid/ready single-precision compare/select unit
// (FEQ, FLT, FLE, FMIN, FMAX) with destination tag and reserved-op flag.
module fcmp_unit #(
    parameter int unsigned TAG_W = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam int unsigned DATA_W   = 32;
    localparam logic [DATA_W-1:0] NEG_ZERO = 32'h8000_0000;
    localparam logic [DATA_W-1:0] POS_ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        OP_FEQ  = 3'd0,
        OP_FLT  = 3'd1,
        OP_FLE  = 3'd2,
        OP_FMIN = 3'd3,
        OP_FMAX = 3'd4
    } op_e;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    logic [2:0]        s1_op;
    logic [TAG_W-1:0]  s1_tag;
    logic              s2_valid;

    logic              s2_adv;
    logic              lt;
    logic              eq;
    logic [DATA_W-1:0] res;
    logic              res_illegal;

    // Handshake: ready path is combinational from out_ready.
    always_comb begin
        s2_adv   = ~s2_valid | out_ready;
        in_ready = ~s1_valid | s2_adv;
    end

    assign out_valid = s2_valid;

    // Sign-magnitude less-than / equal on the S1 operands, then result select.
    always_comb begin
        lt          = 1'b0;
        eq          = 1'b0;
        res         = '0;
        res_illegal = 1'b0;

        if (s1_a == NEG_ZERO && s1_b == POS_ZERO) begin
            lt = 1'b0;
        end else if (s1_a[31] && !s1_b[31]) begin
            lt = 1'b1;
        end else if (s1_a[31] && s1_b[31]) begin
            lt = (s1_a[30:0] > s1_b[30:0]);
        end else if (!s1_a[31] && !s1_b[31]) begin
            lt = (s1_a[30:0] < s1_b[30:0]);
        end

        eq = (s1_a == s1_b)
           || (s1_a == NEG_ZERO && s1_b == POS_ZERO)
           || (s1_a == POS_ZERO && s1_b == NEG_ZERO);

        case (s1_op)
            OP_FEQ:  res = {31'b0, eq};
            OP_FLT:  res = {31'b0, lt};
            OP_FLE:  res = {31'b0, lt | eq};
            OP_FMIN: res = (lt | eq) ? s1_a : s1_b;
            OP_FMAX: res = lt ? s1_b : s1_a;
            default: res_illegal = 1'b1;
        endcase
    end

    // Pipeline registers: reset, then flush, then normal advance/hold.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid    <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_op       <= '0;
            s1_tag      <= '0;
            s2_valid    <= 1'b0;
            out_data    <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data    <= res;
                    out_tag     <= s1_tag;
                    out_illegal <= res_illegal;
                end
            end
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_a   <= in_a;
                    s1_b   <= in_b;
                    s1_op  <= in_op;
                    s1_tag <= in_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_fcmp_unit.sv
// Testbench for fcmp_unit: directed scenarios plus randomized traffic
// checked against an ordered-key reference model.
module tb_fcmp_unit;

    localparam int unsigned TAG_W = 6;

    logic             clk;
    logic             rstn;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    fcmp_unit #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } exp_t;

    exp_t             q[$];
    exp_t             e;
    int               checks = 0;
    int               errors = 0;
    logic             acc;
    logic             outx;
    logic [31:0]      s_data;
    logic [TAG_W-1:0] s_tag;
    logic             s_ill;

    // Map a sign-magnitude word to a signed ordering key; +0 and -0 share key 0.
    function automatic longint fkey(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? -m : m;
    endfunction

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [TAG_W-1:0] tag);
        exp_t r;
        logic lt, eq;
        lt = (fkey(a) < fkey(b));
        eq = (fkey(a) == fkey(b));
        r.tag = tag;
        r.ill = 1'b0;
        case (op)
            3'd0:    r.data = {31'b0, eq};
            3'd1:    r.data = {31'b0, lt};
            3'd2:    r.data = {31'b0, lt | eq};
            3'd3:    r.data = (lt | eq) ? a : b;
            3'd4:    r.data = lt ? b : a;
            default: begin r.data = 32'h0; r.ill = 1'b1; end
        endcase
        return r;
    endfunction

    // Drive one cycle of inputs, record the handshakes seen, advance to next negedge.
    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] tag,
                        input logic ordy, input logic fl);
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        out_ready = ordy;
        flush     = fl;
        #1;
        acc    = in_valid & in_ready & ~flush;
        outx   = out_valid & out_ready;
        s_data = out_data;
        s_tag  = out_tag;
        s_ill  = out_illegal;
        if (acc) q.push_back(model(op, a, b, tag));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 3'd0, 32'h0, 32'h0, '0, ordy, 1'b0);
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return {1'b1, 31'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        idle(1'b1);
        idle(1'b1);
        rstn = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        checks++;
        if (out_data !== 32'h0 || out_tag !== '0 || out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: data=%h tag=%0d ill=%b required 0/0/0", out_data, out_tag, out_illegal);
        end
        @(negedge clk);
        q.delete();
    endtask

    task automatic test_single();
        step(1'b1, 3'd1, 32'hBF80_0000, 32'h3F80_0000, 6'd5, 1'b1, 1'b0);
        checks++;
        if (acc !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: acc=%b out_valid=%b required 1/0", acc, out_valid);
        end
        idle(1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h1 || out_tag !== 6'd5) begin
            errors++;
            $display("FAIL single_latency: valid=%b data=%h tag=%0d required 1/1/5", out_valid, out_data, out_tag);
        end
        idle(1'b1);
        checks++;
        if (outx !== 1'b1 || q.size() != 1 || s_data !== 32'h1) begin
            errors++;
            $display("FAIL single_consume: outx=%b qsize=%0d data=%h required 1/1/1", outx, q.size(), s_data);
        end
        q.delete();
    endtask

    task automatic test_zero();
        logic [2:0]  ops[4];
        logic [31:0] as[4];
        logic [31:0] bs[4];
        logic [31:0] req[4];
        int          n;
        ops = '{3'd1, 3'd0, 3'd2, 3'd3};
        as  = '{32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
        bs  = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000};
        req = '{32'h0, 32'h1, 32'h1, 32'h0000_0000};
        n = 0;
        for (int k = 0; k < 10 && n < 4; k++) begin
            if (k < 4) step(1'b1, ops[k], as[k], bs[k], 6'(10 + k), 1'b1, 1'b0);
            else       idle(1'b1);
            if (outx) begin
                e = q.pop_front();
                checks++;
                if (s_data !== req[n] || s_tag !== 6'(10 + n) || s_data !== e.data) begin
                    errors++;
                    $display("FAIL zero_case%0d: data=%h tag=%0d required %h/%0d", n, s_data, s_tag, req[n], 10 + n);
                end
                n++;
            end
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL zero_count: got %0d results required 4", n);
        end
    endtask

    task automatic test_back_to_back();
        int first, last, n;
        logic [2:0]  op;
        logic [31:0] a, b;
        first = -1; last = -1; n = 0;
        for (int k = 0; k < 14; k++) begin
            if (k < 8) begin
                op = 3'($urandom_range(0, 4));
                a  = rand_word();
                b  = rand_word();
                if (k == 0) begin op = 3'd4; a = 32'h4040_0000; b = 32'h4000_0000; end
                if (k == 1) begin op = 3'd3; a = 32'hC000_0000; b = 32'hC040_0000; end
                step(1'b1, op, a, b, 6'(20 + k), 1'b1, 1'b0);
                checks++;
                if (acc !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_accept%0d: acc=%b required 1", k, acc);
                end
            end else begin
                idle(1'b1);
            end
            if (outx) begin
                if (first < 0) first = k;
                last = k;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious: data=%h tag=%0d required no result", s_data, s_tag);
                end else begin
                    e = q.pop_front();
                    if ({s_data, s_tag, s_ill} !== e || s_tag !== 6'(20 + n)) begin
                        errors++;
                        $display("FAIL b2b_result%0d: data=%h tag=%0d required %h/%0d", n, s_data, s_tag, e.data, e.tag);
                    end
                end
                if (n == 0 && s_data !== 32'h4040_0000) begin
                    errors++;
                    $display("FAIL b2b_fmax: data=%h required 40400000", s_data);
                end
                if (n == 1 && s_data !== 32'hC040_0000) begin
                    errors++;
                    $display("FAIL b2b_fmin: data=%h required c0400000", s_data);
                end
                n++;
            end
        end
        checks++;
        if (n != 8 || first != 2 || last - first != 7) begin
            errors++;
            $display("FAIL b2b_timing: n=%0d first=%0d span=%0d required 8/2/7", n, first, last - first);
        end
    endtask

    task automatic test_stall();
        int          nacc, n;
        logic        seen;
        logic [31:0] hd;
        logic [TAG_W-1:0] ht;
        nacc = 0; n = 0; seen = 1'b0; hd = '0; ht = '0;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 3'($urandom_range(0, 4)), rand_word(), rand_word(), 6'(30 + k), 1'b0, 1'b0);
            if (acc) nacc++;
            if (seen) begin
                checks++;
                if (s_data !== hd || s_tag !== ht) begin
                    errors++;
                    $display("FAIL stall_stable: data=%h tag=%0d required %h/%0d", s_data, s_tag, hd, ht);
                end
            end
            if (out_valid) begin seen = 1'b1; hd = out_data; ht = out_tag; end
        end
        #1;
        checks++;
        if (nacc != 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_accept: accepted=%0d in_ready=%b required 2/0", nacc, in_ready);
        end
        for (int k = 0; k < 6; k++) begin
            idle(1'b1);
            if (outx) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stall_dup: tag=%0d required no result", s_tag);
                end else begin
                    e = q.pop_front();
                    if ({s_data, s_tag, s_ill} !== e || s_tag !== 6'(30 + n)) begin
                        errors++;
                        $display("FAIL stall_drain%0d: data=%h tag=%0d required %h/%0d", n, s_data, s_tag, e.data, e.tag);
                    end
                end
                n++;
            end
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL stall_count: got %0d results required 2", n);
        end
    endtask

    task automatic test_flush_reset();
        int n;
        step(1'b1, 3'd1, rand_word(), rand_word(), 6'd40, 1'b0, 1'b0);
        step(1'b1, 3'd0, rand_word(), rand_word(), 6'd41, 1'b0, 1'b0);
        step(1'b1, 3'd2, rand_word(), rand_word(), 6'd42, 1'b0, 1'b1);
        q.delete();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: out_valid=%b required 0", out_valid);
        end
        n = 0;
        for (int k = 0; k < 5; k++) begin
            idle(1'b1);
            if (outx) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL flush_leak: got %0d results required 0", n);
        end
        step(1'b1, 3'd1, rand_word(), rand_word(), 6'd43, 1'b0, 1'b0);
        step(1'b1, 3'd4, rand_word(), rand_word(), 6'd44, 1'b0, 1'b0);
        rstn = 1'b0;
        step(1'b1, 3'd3, rand_word(), rand_word(), 6'd45, 1'b1, 1'b0);
        rstn = 1'b1;
        q.delete();
        n = 0;
        for (int k = 0; k < 5; k++) begin
            idle(1'b1);
            if (outx) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL reset_leak: got %0d results required 0", n);
        end
    endtask

    task automatic test_illegal();
        step(1'b1, 3'd6, 32'h3F80_0000, 32'h3F80_0000, 6'd3, 1'b1, 1'b0);
        step(1'b1, 3'd0, 32'h3F80_0000, 32'h3F80_0000, 6'd4, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_data !== 32'h0 || out_tag !== 6'd3) begin
            errors++;
            $display("FAIL illegal_op: valid=%b ill=%b data=%h tag=%0d required 1/1/0/3",
                     out_valid, out_illegal, out_data, out_tag);
        end
        idle(1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_illegal !== 1'b0 || out_data !== 32'h1 || out_tag !== 6'd4) begin
            errors++;
            $display("FAIL illegal_follow: valid=%b ill=%b data=%h tag=%0d required 1/0/1/4",
                     out_valid, out_illegal, out_data, out_tag);
        end
        idle(1'b1);
        q.delete();
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic        fl;
        for (int k = 0; k < 600; k++) begin
            a = rand_word();
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = {a[31:23], 23'($urandom)};
                default: b = rand_word();
            endcase
            fl = ($urandom_range(0, 39) == 0);
            step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), a, b,
                 6'($urandom), 1'($urandom_range(0, 2) != 0), fl);
            if (outx) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious: data=%h tag=%0d required no result", s_data, s_tag);
                end else begin
                    e = q.pop_front();
                    if ({s_data, s_tag, s_ill} !== e) begin
                        errors++;
                        $display("FAIL rand_result: data=%h tag=%0d ill=%b required %h/%0d/%b",
                                 s_data, s_tag, s_ill, e.data, e.tag, e.ill);
                    end
                end
            end
            if (fl) q.delete();
        end
        for (int k = 0; k < 10; k++) begin
            idle(1'b1);
            if (outx) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_drain_spurious: tag=%0d required no result", s_tag);
                end else begin
                    e = q.pop_front();
                    if ({s_data, s_tag, s_ill} !== e) begin
                        errors++;
                        $display("FAIL rand_drain: data=%h tag=%0d required %h/%0d", s_data, s_tag, e.data, e.tag);
                    end
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rand_lost: %0d results outstanding required 0", q.size());
        end
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0;
        in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_zero();
        test_back_to_back();
        test_stall();
        test_flush_reset();
        test_illegal();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
